// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Ceiling log2, used to size the prescaler phase register.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: emits one tick every DIV enabled cycles.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A divide-by-1 still needs a one-bit register to keep the code uniform.
    localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase;

    // Phase advances only on enabled cycles; en=0 freezes it, clr restarts it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

    // Tick is combinational so the count steps on the edge closing the period.
    always_comb begin
        tick = en && !clr && (phase == LAST);
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, prescaler, wrap/saturate and overflow flag.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MOD_MAX   = 2**WIDTH - 1,
    parameter int unsigned PRESC_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_MAX);

    logic             tick;
    logic             boundary;
    logic [WIDTH-1:0] load_clamped;

    // A load restarts the prescaler period so the next step is a full period away.
    counter_prescaler #(
        .DIV (PRESC_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    // Terminal count depends on the live dir so it follows a direction change at once.
    always_comb begin
        tc           = (dir == DIR_UP) ? (count == MAX_VAL) : (count == '0);
        boundary     = tick && tc;
        load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    // Count register: load beats a tick step; boundaries wrap explicitly or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
        end else if (load) begin
            count      <= load_clamped;
            wrap_pulse <= 1'b0;
        end else if (tick) begin
            wrap_pulse <= boundary;
            if (boundary) begin
                if (sat_mode == MODE_WRAP) begin
                    count <= (dir == DIR_UP) ? '0 : MAX_VAL;
                end
            end else begin
                count <= (dir == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
            end
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

    // Sticky overflow: a boundary step in the same cycle outranks a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (!load && boundary) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule
